// File: rtl/phys_frame_sequencer_pkg.sv
// rtl/phys_frame_sequencer_pkg.sv - shared types and constants for the physics frame sequencer
// Package phys_pkg: fixed-point widths, FSM state encoding, hit_dir bit positions,
// default per-contact force magnitude. No ports.
package phys_pkg;

   localparam int FIX_W  = 17;
   localparam int FRAC_W = 6;

   // 0.5 px/frame in 10.6 signed fixed point
   localparam logic [FIX_W-1:0] FORCE_MAG_DEF = 17'd32;

   // Bit positions inside each pig's hit_dir nibble {h_band, v_band, right_of_centre, below_centre}
   localparam int DIR_BELOW = 0;
   localparam int DIR_RIGHT = 1;
   localparam int DIR_VBAND = 2;
   localparam int DIR_HBAND = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PH1,
      ST_WAIT1,
      ST_PH2,
      ST_WAIT2,
      ST_PH3
   } state_t;

endpackage

// File: rtl/phys_frame_sequencer_pig_contact_latch.sv
// rtl/phys_frame_sequencer_pig_contact_latch.sv - per-pig sticky contact flags and force latch
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   hit, dir          current pixel overlaps this pig; direction nibble
//   clear             restart flag accumulation (current hit still lands in new flags)
//   latch             capture force pair from the flags as they were before this edge
//   zero              return both forces to 0
//   force_x, force_y  signed 17-bit force pair
module pig_contact_latch
   import phys_pkg::*;
#(
   parameter logic [FIX_W-1:0] FORCE_MAG = FORCE_MAG_DEF
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             hit,
   input  logic [3:0]       dir,
   input  logic             clear,
   input  logic             latch,
   input  logic             zero,
   output logic [FIX_W-1:0] force_x,
   output logic [FIX_W-1:0] force_y
);

   logic flag_l, flag_r, flag_t, flag_b;
   logic hit_l, hit_r, hit_t, hit_b;
   logic [FIX_W-1:0] x_pos, x_neg, y_pos, y_neg;

   assign hit_l = hit & dir[DIR_VBAND] & ~dir[DIR_RIGHT];
   assign hit_r = hit & dir[DIR_VBAND] &  dir[DIR_RIGHT];
   assign hit_t = hit & dir[DIR_HBAND] & ~dir[DIR_BELOW];
   assign hit_b = hit & dir[DIR_HBAND] &  dir[DIR_BELOW];

   // Opposing contacts subtract to zero; 2*FORCE_MAG never needs saturation
   assign x_pos = flag_l ? FORCE_MAG : '0;
   assign x_neg = flag_r ? FORCE_MAG : '0;
   assign y_pos = flag_t ? FORCE_MAG : '0;
   assign y_neg = flag_b ? FORCE_MAG : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         flag_l <= 1'b0;
         flag_r <= 1'b0;
         flag_t <= 1'b0;
         flag_b <= 1'b0;
      end else if (clear) begin
         flag_l <= hit_l;
         flag_r <= hit_r;
         flag_t <= hit_t;
         flag_b <= hit_b;
      end else begin
         flag_l <= flag_l | hit_l;
         flag_r <= flag_r | hit_r;
         flag_t <= flag_t | hit_t;
         flag_b <= flag_b | hit_b;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || zero) begin
         force_x <= '0;
         force_y <= '0;
      end else if (latch) begin
         force_x <= x_pos - x_neg;
         force_y <= y_pos - y_neg;
      end
   end

endmodule

// File: rtl/phys_frame_sequencer.sv
// rtl/phys_frame_sequencer.sv - once-per-frame three-phase physics update scheduler
// Optional feature macro: PHYS_SINGLE_STEP_EN (adds the step input).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   vga_vsync                 raw active-low VGA vsync
//   pause                     suppresses physics sequences
//   step                      (PHYS_SINGLE_STEP_EN only) single sequence while paused
//   hit, hit_dir              per-pixel bird/pig overlap and direction nibbles
//   vsync, vsync2, vsync3     single-cycle phase strobes
//   pig_force_x, pig_force_y  per-pig 17-bit signed forces
//   busy                      high from the frame edge through the vsync3 cycle
//   frame_cnt                 completed update sequences, wraps
module phys_frame_sequencer
   import phys_pkg::*;
#(
   parameter int               NUM_PIGS  = 4,
   parameter int               GAP       = 4,
   parameter logic [FIX_W-1:0] FORCE_MAG = FORCE_MAG_DEF
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      vga_vsync,
   input  logic                      pause,
`ifdef PHYS_SINGLE_STEP_EN
   input  logic                      step,
`endif
   input  logic [NUM_PIGS-1:0]       hit,
   input  logic [4*NUM_PIGS-1:0]     hit_dir,
   output logic                      vsync,
   output logic                      vsync2,
   output logic                      vsync3,
   output logic [FIX_W*NUM_PIGS-1:0] pig_force_x,
   output logic [FIX_W*NUM_PIGS-1:0] pig_force_y,
   output logic                      busy,
   output logic [15:0]               frame_cnt
);

   // Wait states last GAP-1 cycles; the counter runs 0..GAP-2
   localparam int WAIT_LAST = (GAP > 1) ? GAP - 2 : 0;
   localparam int CW        = (GAP > 2) ? $clog2(GAP - 1) : 1;

   state_t          state_q, state_d;
   logic            vsync_q;
   logic            frame_edge;
   logic            start;
   logic            clear;
   logic            zero;
   logic [CW-1:0]   wait_cnt;
   logic            wait_done;

   assign frame_edge = ~vga_vsync & vsync_q;
   assign wait_done  = (wait_cnt == CW'(WAIT_LAST));
   assign zero       = (state_q == ST_PH3);

`ifdef PHYS_SINGLE_STEP_EN
   assign start = (state_q == ST_IDLE) & ((frame_edge & ~pause) | (step & pause));
`else
   assign start = (state_q == ST_IDLE) & frame_edge & ~pause;
`endif

   // Flags restart on every IDLE edge, paused or not; edges during a sequence leave them alone
   assign clear = (state_q == ST_IDLE) & (frame_edge | start);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_PH1;
         ST_PH1:   state_d = (GAP > 1) ? ST_WAIT1 : ST_PH2;
         ST_WAIT1: if (wait_done) state_d = ST_PH2;
         ST_PH2:   state_d = (GAP > 1) ? ST_WAIT2 : ST_PH3;
         ST_WAIT2: if (wait_done) state_d = ST_PH3;
         ST_PH3:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Strobes and busy are registered from the next state so they line up with the state itself
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         vsync_q   <= 1'b1;
         wait_cnt  <= '0;
         vsync     <= 1'b0;
         vsync2    <= 1'b0;
         vsync3    <= 1'b0;
         busy      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state_q <= state_d;
         vsync_q <= vga_vsync;
         if (state_q == ST_WAIT1 || state_q == ST_WAIT2)
            wait_cnt <= wait_done ? '0 : wait_cnt + CW'(1);
         else
            wait_cnt <= '0;
         vsync  <= (state_d == ST_PH1);
         vsync2 <= (state_d == ST_PH2);
         vsync3 <= (state_d == ST_PH3);
         busy   <= (state_d != ST_IDLE);
         if (state_q == ST_PH3)
            frame_cnt <= frame_cnt + 16'd1;
      end
   end

   for (genvar i = 0; i < NUM_PIGS; i++) begin : g_pig
      pig_contact_latch #(
         .FORCE_MAG (FORCE_MAG)
      ) u_latch (
         .clk     (clk),
         .rst     (rst),
         .hit     (hit[i]),
         .dir     (hit_dir[4*i +: 4]),
         .clear   (clear),
         .latch   (start),
         .zero    (zero),
         .force_x (pig_force_x[FIX_W*i +: FIX_W]),
         .force_y (pig_force_y[FIX_W*i +: FIX_W])
      );
   end

endmodule

// File: tb/tb_phys_frame_sequencer.sv
// tb/tb_phys_frame_sequencer.sv - directed self-checking bench for phys_frame_sequencer
module tb_phys_frame_sequencer;

   localparam int          NP  = 4;
   localparam int          GAP = 4;
   localparam logic [16:0] FP  = 17'd32;
   localparam logic [16:0] FN  = 17'h1FFE0;
   localparam logic [16:0] Z   = 17'd0;

   localparam int M_EDGE   = 0;
   localparam int M_PAUSED = 1;
   localparam int M_GLITCH = 2;
   localparam int M_STEP   = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            vga_vsync = 1'b1;
   logic            pause = 1'b0;
   logic [NP-1:0]   hit = '0;
   logic [4*NP-1:0] hit_dir = '0;
   logic            vsync, vsync2, vsync3, busy;
   logic [17*NP-1:0] pig_force_x, pig_force_y;
   logic [15:0]     frame_cnt;
`ifdef PHYS_SINGLE_STEP_EN
   logic            step = 1'b0;
`endif

   int          n_checks = 0;
   int          n_fail = 0;
   logic [15:0] exp_frame = 16'd0;

   always #5 clk = ~clk;

   phys_frame_sequencer #(
      .NUM_PIGS  (NP),
      .GAP       (GAP),
      .FORCE_MAG (FP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .vga_vsync   (vga_vsync),
      .pause       (pause),
`ifdef PHYS_SINGLE_STEP_EN
      .step        (step),
`endif
      .hit         (hit),
      .hit_dir     (hit_dir),
      .vsync       (vsync),
      .vsync2      (vsync2),
      .vsync3      (vsync3),
      .pig_force_x (pig_force_x),
      .pig_force_y (pig_force_y),
      .busy        (busy),
      .frame_cnt   (frame_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hit_pig(input int i, input logic [3:0] d);
      hit = '0;
      hit[i] = 1'b1;
      hit_dir[4*i +: 4] = d;
      tick();
      hit = '0;
   endtask

   // Launches one frame edge (or step) in the current cycle E and checks cycles E+1..E+12.
   // eh/ed: hit applied in the edge cycle itself. Glitch mode adds a second edge at E+3
   // with hits on pig1 (L) and pig3 (T).
   task automatic frame(input string name, input int mode,
                        input logic [17*NP-1:0] ex, input logic [17*NP-1:0] ey,
                        input logic [NP-1:0] eh, input logic [3:0] ed);
      logic seq;
      logic [16:0] fx_exp, fy_exp;
      seq = (mode != M_PAUSED);
      hit = eh;
      for (int i = 0; i < NP; i++)
         if (eh[i]) hit_dir[4*i +: 4] = ed;
      if (mode == M_PAUSED) pause = 1'b1;
      if (mode == M_STEP) begin
         pause = 1'b1;
`ifdef PHYS_SINGLE_STEP_EN
         step = 1'b1;
`endif
      end else begin
         vga_vsync = 1'b0;
      end
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 1) begin
            hit = '0;
`ifdef PHYS_SINGLE_STEP_EN
            step = 1'b0;
`endif
         end
         check($sformatf("%s k%0d vsync", name, k), {31'd0, vsync}, {31'd0, seq && k == 1});
         check($sformatf("%s k%0d vsync2", name, k), {31'd0, vsync2}, {31'd0, seq && k == 1 + GAP});
         check($sformatf("%s k%0d vsync3", name, k), {31'd0, vsync3}, {31'd0, seq && k == 1 + 2*GAP});
         check($sformatf("%s k%0d busy", name, k), {31'd0, busy}, {31'd0, seq && k <= 1 + 2*GAP});
         check($sformatf("%s k%0d frame_cnt", name, k), {16'd0, frame_cnt},
               {16'd0, (seq && k >= 2 + 2*GAP) ? 16'(exp_frame + 16'd1) : exp_frame});
         for (int i = 0; i < NP; i++) begin
            fx_exp = (seq && k <= 1 + 2*GAP) ? ex[17*i +: 17] : Z;
            fy_exp = (seq && k <= 1 + 2*GAP) ? ey[17*i +: 17] : Z;
            check($sformatf("%s k%0d fx%0d", name, k, i), {15'd0, pig_force_x[17*i +: 17]}, {15'd0, fx_exp});
            check($sformatf("%s k%0d fy%0d", name, k, i), {15'd0, pig_force_y[17*i +: 17]}, {15'd0, fy_exp});
         end
         if (mode == M_GLITCH && k == 2) vga_vsync = 1'b1;
         if (mode == M_GLITCH && k == 3) begin
            vga_vsync = 1'b0;
            hit = 4'b1010;
            hit_dir[7:4]   = 4'b0100;
            hit_dir[15:12] = 4'b1000;
         end
         if ((mode != M_GLITCH && k == 3) || k == 4) begin
            vga_vsync = 1'b1;
            hit = '0;
         end
      end
      if (seq) exp_frame = exp_frame + 16'd1;
      pause = 1'b0;
   endtask

   initial begin
      repeat (2) tick();
      check("rst vsync", {31'd0, vsync}, 32'd0);
      check("rst vsync2", {31'd0, vsync2}, 32'd0);
      check("rst vsync3", {31'd0, vsync3}, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst frame_cnt", {16'd0, frame_cnt}, 32'd0);
      check("rst fx", {28'd0, |pig_force_x, |pig_force_y, 2'b00}, 32'd0);
      rst = 1'b0;
      repeat (95) tick();

      // plain frame, no contacts
      frame("A", M_EDGE, {Z, Z, Z, Z}, {Z, Z, Z, Z}, '0, 4'h0);

      // pig0 R; pig2 L+B; pig1 L+R cancel; pig3 T
      hit_pig(0, 4'b0110);
      hit_pig(2, 4'b0100);
      hit_pig(2, 4'b1001);
      hit_pig(1, 4'b0100);
      hit_pig(1, 4'b0110);
      hit_pig(3, 4'b1000);
      repeat (3) tick();
      frame("B", M_EDGE, {Z, FP, Z, FN}, {FP, FN, Z, Z}, '0, 4'h0);

      // flags were cleared by B's edge; a hit with no band flags nothing
      hit_pig(1, 4'b0011);
      repeat (3) tick();
      frame("C", M_EDGE, {Z, Z, Z, Z}, {Z, Z, Z, Z}, '0, 4'h0);

      // paused edge discards pig0's contact
      hit_pig(0, 4'b0110);
      repeat (3) tick();
      frame("P", M_PAUSED, {Z, Z, Z, Z}, {Z, Z, Z, Z}, '0, 4'h0);
      frame("D", M_EDGE, {Z, Z, Z, Z}, {Z, Z, Z, Z}, '0, 4'h0);

      // glitch edge at E+3 ignored; edge-cycle hit and E+3 hits carry to next frame
      hit_pig(2, 4'b0100);
      hit_pig(2, 4'b0110);
      hit_pig(2, 4'b1000);
      repeat (3) tick();
      frame("G", M_GLITCH, {Z, Z, Z, Z}, {Z, FP, Z, Z}, 4'b0001, 4'b0110);
      frame("H", M_EDGE, {Z, Z, FP, FN}, {FP, Z, Z, Z}, '0, 4'h0);

`ifdef PHYS_SINGLE_STEP_EN
      hit_pig(3, 4'b1001);
      repeat (3) tick();
      frame("S", M_STEP, {Z, Z, Z, Z}, {FN, Z, Z, Z}, '0, 4'h0);
`endif

      // reset during E+3 aborts the sequence
      hit_pig(0, 4'b0110);
      repeat (3) tick();
      vga_vsync = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 1) begin
            check("R k1 vsync", {31'd0, vsync}, 32'd1);
            check("R k1 fx0", {15'd0, pig_force_x[16:0]}, {15'd0, FN});
         end
         if (k == 3) check("R k3 busy", {31'd0, busy}, 32'd1);
         if (k >= 4) begin
            check($sformatf("R k%0d vsync2", k), {31'd0, vsync2}, 32'd0);
            check($sformatf("R k%0d vsync3", k), {31'd0, vsync3}, 32'd0);
            check($sformatf("R k%0d busy", k), {31'd0, busy}, 32'd0);
            check($sformatf("R k%0d frame_cnt", k), {16'd0, frame_cnt}, 32'd0);
            check($sformatf("R k%0d fx0", k), {15'd0, pig_force_x[16:0]}, 32'd0);
         end
         if (k == 3) begin
            rst = 1'b1;
            vga_vsync = 1'b1;
         end
         if (k == 4) rst = 1'b0;
      end
      exp_frame = 16'd0;
      frame("Q", M_EDGE, {Z, Z, Z, Z}, {Z, Z, Z, Z}, '0, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/phys_frame_sequencer.md
# phys_frame_sequencer

Frame-level scheduler for the physics datapath. Watches the VGA vertical sync and, once per frame, runs the three-phase update that every pig object expects: force/gravity, border response, position. While the frame is scanned it also collects per-pixel bird/pig overlap reports and converts them into the per-pig `pig_force_x` / `pig_force_y` values that phase 1 consumes. Sits between the VGA controller and the array of pig instances in the top level.

## Interface

**Parameters**
- `NUM_PIGS`, 4: number of pig objects served.
- `GAP`, 4: cycles between consecutive phase strobes, minimum 1.
- `FORCE_MAG`, 17'd32: force per contact in 10.6 signed fixed point (0.5 px/frame).

**Ports**
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `vga_vsync` input 1: raw VGA vsync, active-low, same clock domain.
- `pause` input 1: level; suppresses physics updates.
- `hit` input NUM_PIGS: bit i high when the current pixel is both bird and pig i.
- `hit_dir` input 4*NUM_PIGS: pig i direction nibble at [4i+3:4i], bits {h_band, v_band, right_of_centre, below_centre}.
- `vsync`, `vsync2`, `vsync3` output 1 each: single-cycle phase strobes.
- `pig_force_x`, `pig_force_y` output 17*NUM_PIGS: signed force for pig i at [17i+16:17i].
- `busy` output 1: high from frame edge through the `vsync3` cycle.
- `frame_cnt` output 16: count of completed update sequences, wraps.

## Operation
- Frame edge: cycle where `vga_vsync` is 0 and its registered copy is 1.
- FSM states: IDLE → PH1 → WAIT1 → PH2 → WAIT2 → PH3 → IDLE.
  - IDLE: on frame edge with `pause`=0, latch forces, clear contact flags, go to PH1.
  - PH1: `vsync`=1. Then WAIT1 for GAP−1 cycles (skipped when GAP=1).
  - PH2: `vsync2`=1. Then WAIT2 for GAP−1 cycles.
  - PH3: `vsync3`=1, zero all forces, increment `frame_cnt`, return to IDLE.
- Paused frame edge: contact flags cleared, forces stay 0, no strobes, `frame_cnt` unchanged.
- Frame edge outside IDLE is ignored. Flags are not cleared.
- Contact flags: four sticky flags per pig, set whenever `hit[i]` is high.
  - L: v_band & !right_of_centre.
  - R: v_band & right_of_centre.
  - T: h_band & !below_centre.
  - B: h_band & below_centre.
- Flags accumulate in every state. On the edge cycle the flags are cleared, and a hit in that same cycle lands in the new frame's flags.
- Force on latch:
  - x = (L ? +FORCE_MAG : 0) + (R ? −FORCE_MAG : 0).
  - y = (T ? +FORCE_MAG : 0) + (B ? −FORCE_MAG : 0).
  - Opposing contacts cancel to 0.
  - 17-bit two's complement, no saturation needed.
- Reset: state IDLE. All strobes 0, `busy` 0, forces 0, flags 0, `frame_cnt` 0. The vsync history register is set to 1, so a low `vga_vsync` right after reset produces an edge.
- Reset asserted mid-sequence aborts it immediately. No further strobes are issued.

## Timing
- Frame edge at cycle E:
  - forces valid and `busy`=1 from E+1;
  - `vsync` at E+1, `vsync2` at E+1+GAP, `vsync3` at E+1+2·GAP;
  - forces return to 0 and `frame_cnt` increments at E+2+2·GAP;
  - `busy` falls at E+2+2·GAP.
- Forces are constant from E+1 through the `vsync3` cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `PHYS_SINGLE_STEP_EN` defined: adds input `step` (1 bit). In IDLE with `pause`=1, a `step` pulse starts a sequence exactly as a frame edge would, using current flags, which are then cleared. `step` is ignored when `pause`=0 or outside IDLE.
- Undefined: no `step` port. `pause` blocks all sequences.

## Structure
- Package `phys_pkg` holds:
  - `FIX_W`=17 and `FRAC_W`=6;
  - the FSM state enum;
  - the `hit_dir` bit-index constants;
  - the default `FORCE_MAG`.
- Sub-module `pig_contact_latch`, instantiated NUM_PIGS times. It holds the four sticky flags, takes the clear and latch controls, and outputs that pig's force pair.
- The FSM, edge detect and `frame_cnt` live in the top module.

## Test plan
- Reset, then a vsync falling edge at cycle 100 with GAP=4 → strobes at 101, 105, 109; `busy` 101–109; `frame_cnt`=1 at 110.
- Pig 0 hit with `hit_dir`=4'b0110 (v_band, right) during the frame → at the edge, `pig_force_x[0]` = −32 (17'h1FFE0) and `pig_force_y[0]` = 0; forces return to 0 at E+10.
- Pig 2 hit with both L and B contacts → x=+32, y=−32. Pig 2 also hit with L and R → x=0.
- `pause`=1 at the edge → no strobes, `frame_cnt` unchanged; flags cleared, so the next unpaused edge yields zero force.
- Second falling edge at E+3 (glitch) → ignored, strobe sequence unchanged. A hit at E+3 appears in the next frame's force.
- `rst` pulsed at E+3 → no `vsync2`/`vsync3`; all outputs 0 next cycle. With `PHYS_SINGLE_STEP_EN` defined, `pause`=1 plus `step` → one full sequence.
